// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the matrix SRAM port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int REQ_A  = 0;
  localparam int REQ_X  = 1;
  localparam int REQ_WB = 2;

  localparam int NREQ_D   = 3;
  localparam int ADDR_W_D = 8;
  localparam int DATA_W_D = 32;
  localparam int BLEN_W_D = 6;

  function automatic logic [1:0] oh2idx(input logic [NREQ_D-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[REQ_X])  idx = 2'd1;
    if (oh[REQ_WB]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin pick over three requesters: search upward from ptr with wrap,
// skipping any requester set in excl.
module rr_pick import mem_arb_pkg::*; (
  input  logic [NREQ_D-1:0] req,
  input  logic [1:0]        ptr,
  input  logic [NREQ_D-1:0] excl,
  output logic [NREQ_D-1:0] win,
  output logic              found
);

  logic [NREQ_D-1:0] elig;
  assign elig = req & ~excl;

  always_comb begin
    logic [1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < NREQ_D; k++) begin
      idx = 2'((int'(ptr) + k) % NREQ_D);
      if (!found && elig[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Burst-granting round-robin arbiter for the single-port matrix SRAM.
// Optional per-requester beat counters under MEM_ARB_STATS_EN.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int NREQ   = NREQ_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int BLEN_W = BLEN_W_D
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0][BLEN_W-1:0]   burst_len,
  input  logic [NREQ-1:0][ADDR_W-1:0]   addr,
  input  logic [NREQ-1:0][DATA_W-1:0]   wdata,
  input  logic [NREQ-1:0]               we,
  output logic [NREQ-1:0]               gnt,
  output logic [DATA_W-1:0]             rdata,
  output logic [NREQ-1:0]               rvalid,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic                          busy,
  output logic [1:0]                    owner
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NREQ-1:0][15:0]         stat_beats
`endif
);

  arb_state_e        state_q, state_n;
  logic [NREQ-1:0]   gnt_q, gnt_n, rvalid_q;
  logic [1:0]        owner_q, owner_n, ptr_q, ptr_n, nxt_ptr;
  logic [BLEN_W-1:0] len_q, len_n, cnt_q, cnt_n, pick_len;
  logic [NREQ-1:0]   pick_win, pick_excl;
  logic [1:0]        pick_ptr, pick_idx;
  logic              pick_found, beat, last;

  assign nxt_ptr = (owner_q == 2'(NREQ - 1)) ? 2'd0 : owner_q + 2'd1;
  assign beat    = (state_q == GRANT) && req[owner_q];
  assign last    = beat && (cnt_q == len_q - BLEN_W'(1));

  // One picker serves both arbitrations: from the RR pointer when idle, and
  // from owner+1 with the finishing owner masked at end of burst.
  assign pick_ptr  = (state_q == GRANT) ? nxt_ptr : ptr_q;
  assign pick_excl = (state_q == GRANT) ? gnt_q : '0;

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .win   (pick_win),
    .found (pick_found)
  );

  assign pick_idx = oh2idx(pick_win);
  assign pick_len = (burst_len[pick_idx] == '0) ? BLEN_W'(1) : burst_len[pick_idx];

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    owner_n = owner_q;
    ptr_n   = ptr_q;
    len_n   = len_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          gnt_n   = pick_win;
          owner_n = pick_idx;
          len_n   = pick_len;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          state_n = IDLE;
          gnt_n   = '0;
          ptr_n   = nxt_ptr;
          cnt_n   = '0;
        end else if (last) begin
          ptr_n = nxt_ptr;
          cnt_n = '0;
          if (pick_found) begin
            gnt_n   = pick_win;
            owner_n = pick_idx;
            len_n   = pick_len;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end else begin
          cnt_n = cnt_q + BLEN_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_n;
      gnt_q    <= gnt_n;
      owner_q  <= owner_n;
      ptr_q    <= ptr_n;
      len_q    <= len_n;
      cnt_q    <= cnt_n;
      // gnt_q is the owner one-hot, so it doubles as the read-return tag
      rvalid_q <= (beat && !we[owner_q]) ? gnt_q : '0;
    end
  end

  assign ram_en    = beat;
  assign ram_we    = beat && we[owner_q];
  assign ram_addr  = (state_q == GRANT) ? addr[owner_q]  : '0;
  assign ram_wdata = (state_q == GRANT) ? wdata[owner_q] : '0;

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata  = ram_rdata;
  assign busy   = (state_q == GRANT);
  assign owner  = owner_q;

`ifdef MEM_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [15:0] beats_q;
    always_ff @(posedge clk) begin
      if (rst || stat_clr)
        beats_q <= '0;
      else if (beat && gnt_q[i] && beats_q != 16'hFFFF)
        beats_q <= beats_q + 16'd1;
    end
    assign stat_beats[i] = beats_q;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous SRAM model.
module tb_mem_port_arbiter;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          req;
  logic [2:0][5:0]     burst_len;
  logic [2:0][7:0]     addr;
  logic [2:0][31:0]    wdata;
  logic [2:0]          we;
  logic [2:0]          gnt;
  logic [31:0]         rdata;
  logic [2:0]          rvalid;
  logic                ram_en, ram_we;
  logic [7:0]          ram_addr;
  logic [31:0]         ram_wdata;
  logic [31:0]         ram_rdata;
  logic                busy;
  logic [1:0]          owner;
`ifdef MEM_ARB_STATS_EN
  logic                stat_clr;
  logic [2:0][15:0]    stat_beats;
`endif

  int ntest = 0;
  int nfail = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .burst_len (burst_len),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .gnt       (gnt),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .owner     (owner)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_beats(stat_beats)
`endif
  );

  // Single-port SRAM: one-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
    ram_rdata = '0;
    rst = 1'b1; req = '0; burst_len = '0; addr = '0; wdata = '0; we = '0;
`ifdef MEM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    tick(); tick();
    check("rst_gnt",    64'(gnt),    64'h0);
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_busy",   64'(busy),   64'h0);
    check("rst_owner",  64'(owner),  64'h0);
    check("rst_ram_en", 64'(ram_en), 64'h0);
    rst = 1'b0;

    // Single 4-beat read burst on requester 0
    req = 3'b001; burst_len[0] = 6'd4; addr[0] = 8'h10;
    tick();
    check("rd_gnt", 64'(gnt), 64'h1);
    for (int b = 0; b < 4; b++) begin
      addr[0] = 8'(8'h10 + b);
      #1;
      check("rd_ram_en",   64'(ram_en),   64'h1);
      check("rd_ram_we",   64'(ram_we),   64'h0);
      check("rd_ram_addr", 64'(ram_addr), 64'(8'h10 + b));
      tick();
      check("rd_rvalid", 64'(rvalid), 64'h1);
      check("rd_rdata",  64'(rdata),  64'(32'hA000_0010 + b));
    end
    check("rd_gnt_done", 64'(gnt),  64'h0);
    check("rd_busy_done", 64'(busy), 64'h0);
    req = '0;
    tick();
    check("rd_rvalid_done", 64'(rvalid), 64'h0);

    // Contention from pointer 0: grants 0,1,2 back-to-back
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b111; burst_len = {6'd2, 6'd2, 6'd2};
    tick();
    check("cont_g0", 64'(gnt), 64'h1);
    tick();
    tick();
    check("cont_g1", 64'(gnt), 64'h2);
    check("cont_own1", 64'(owner), 64'h1);
    tick();
    tick();
    check("cont_g2", 64'(gnt), 64'h4);
    req = 3'b100;
    tick();
    tick();
    check("cont_idle", 64'(gnt), 64'h0);

    // Zero length: one beat each; pointer is back at 0 so 0 wins over 2
    req = 3'b101; burst_len = {6'd0, 6'd2, 6'd0};
    tick();
    check("zl_g0", 64'(gnt), 64'h1);
    check("zl_en", 64'(ram_en), 64'h1);
    tick();
    check("zl_g2", 64'(gnt), 64'h4);
    req = 3'b100;
    tick();
    check("zl_done", 64'(gnt), 64'h0);
    req = '0;

    // Abort: requester 1 write burst of 28 drops req after 2 beats
    req = 3'b110; burst_len = {6'd1, 6'd28, 6'd0};
    we[1] = 1'b1; wdata[1] = 32'hDEAD_BEEF; addr[1] = 8'h40;
    tick();
    check("ab_g1",    64'(gnt),       64'h2);
    check("ab_own",   64'(owner),     64'h1);
    check("ab_we",    64'(ram_we),    64'h1);
    check("ab_wdata", 64'(ram_wdata), 64'hDEAD_BEEF);
    check("ab_addr",  64'(ram_addr),  64'h40);
    tick(); tick();
    req = 3'b100;
    #1;
    check("ab_no_beat", 64'(ram_en), 64'h0);
    tick();
    check("ab_gnt_drop", 64'(gnt),    64'h0);
    check("ab_busy",     64'(busy),   64'h0);
    check("ab_rvalid",   64'(rvalid), 64'h0);
    req = 3'b110;
    tick();
    check("ab_next_g2", 64'(gnt), 64'h4);
    req = 3'b100;
    tick();
    check("ab_g2_done", 64'(gnt), 64'h0);
    req = '0;

    // Reset during beat 5 of a 10-beat read burst on requester 1
    we[1] = 1'b0; addr[1] = 8'h20; burst_len[1] = 6'd10; req = 3'b010;
    tick();
    check("rm_g1", 64'(gnt), 64'h2);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("rm_gnt",    64'(gnt),    64'h0);
    check("rm_rvalid", 64'(rvalid), 64'h0);
    check("rm_ram_en", 64'(ram_en), 64'h0);
    check("rm_owner",  64'(owner),  64'h0);
    rst = 1'b0;
    tick();
    check("rm_regrant", 64'(gnt), 64'h2);
    repeat (9) tick();
    check("rm_beat9", 64'(gnt), 64'h2);
    tick();
    check("rm_full10", 64'(gnt), 64'h0);
    req = '0;
    tick();

`ifdef MEM_ARB_STATS_EN
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    burst_len[2] = 6'd28;
    for (int n = 0; n < 3; n++) begin
      req = 3'b100;
      tick();
      repeat (28) tick();
      req = '0;
    end
    tick();
    check("st_beats2", 64'(stat_beats[2]), 64'd84);
    check("st_beats0", 64'(stat_beats[0]), 64'd0);
    req = 3'b100;
    tick(); tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("st_clr_beat", 64'(stat_beats[2]), 64'd0);
    req = '0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port matrix SRAM between three requesters: A-matrix loader (0), data/column loader (1) and result writeback (2).
- Grants whole bursts using round-robin priority, muxes each owner's address and data onto the SRAM port, and routes read data back to the owner.
- Sits between the load/writeback engines and the SRAM, beside the matrix controller.

Parameters:
- NREQ, 3, number of requesters; fixed at 3 in this revision.
- ADDR_W, 8, SRAM address width.
- DATA_W, 32, SRAM word width.
- BLEN_W, 6, burst-length field width; maximum burst is 63 beats, so a 28-beat column fits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester burst request; level-held.
- burst_len  in  NREQ*BLEN_W  beats requested; slice i belongs to requester i.
- addr  in  NREQ*ADDR_W  per-requester address, valid while granted.
- wdata  in  NREQ*DATA_W  per-requester write data.
- we  in  NREQ  per-requester write enable.
- gnt  out  NREQ  one-hot grant; every cycle with gnt[i]=1 and req[i]=1 is one beat.
- rdata  out  DATA_W  SRAM read data, shared by all requesters.
- rvalid  out  NREQ  one-hot; marks rdata as belonging to requester i.
- ram_en  out  1  SRAM enable.
- ram_we  out  1  SRAM write enable.
- ram_addr  out  ADDR_W  SRAM address.
- ram_wdata  out  DATA_W  SRAM write data.
- ram_rdata  in  DATA_W  SRAM read data; valid 1 cycle after a read beat.
- busy  out  1  high while in the GRANT state.
- owner  out  2  index of the current or last owner.

Behaviour:
- Reset values: gnt=0, rvalid=0, busy=0, owner=0, RR pointer=0, beat count=0, ram_en=0. Reset mid-burst aborts the burst at that edge; no further beats.
- State machine has two states: IDLE and GRANT.
- IDLE:
  - If any req is high, pick a winner by round-robin: search from the RR pointer upward with wrap.
  - Register gnt one-hot, latch burst_len into len_q (0 is treated as 1), clear the beat count, go to GRANT.
  - Latency from req to gnt is 1 cycle.
- GRANT:
  - Each cycle with req[owner]=1 is a beat. The owner's addr, we and wdata go combinationally to the ram_* ports; ram_en=1; the beat count increments.
  - On the last beat (count==len_q-1), the RR pointer becomes owner+1 (mod 3).
  - If any req other than the finishing owner's is pending, re-arbitrate that same cycle, so the next gnt appears with no bubble.
  - Otherwise drop gnt and go to IDLE.
  - The finishing owner's req is excluded from this same-cycle re-arbitration.
- Abort: req[owner]=0 while in GRANT means no beat that cycle (ram_en=0). The burst terminates, gnt drops next edge, the RR pointer advances, and the next state is IDLE.
- Read return: a beat with we=0 sets rvalid[owner]=1 exactly one cycle later with rdata=ram_rdata. The owner tag is registered, so rvalid still tracks the burst's owner after the grant has changed. rvalid is cleared by reset.
- Outside GRANT: ram_en=0, ram_we=0; ram_addr and ram_wdata are don't-care but driven to 0.
- Simultaneous requests: all three high with pointer=0 gives grant order 0, 1, 2, 0, and so on.
- burst_len changes after grant are ignored.

Optional Feature:
- Macro name: MEM_ARB_STATS_EN.
- When defined:
  - Adds input stat_clr (1) and output stat_beats (NREQ*16).
  - stat_beats holds per-requester 16-bit saturating counters of issued beats; they hold at 0xFFFF.
  - stat_clr synchronously zeroes the counters and takes priority over a same-cycle beat increment.
  - Counters reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE=1'b0, GRANT=1'b1);
  - requester index constants REQ_A=0, REQ_X=1, REQ_WB=2;
  - default widths.
- One combinational sub-module, rr_pick: takes a 3-bit request vector, the pointer and an exclude mask; returns a one-hot winner and a found flag. It is reused for both the IDLE and the end-of-burst arbitration.

Test Plan:
- Single read burst: req[0]=1, len=4, addr 0x10..0x13 -> gnt[0] at cycle 1, four beats with ram_en=1, rvalid[0] on cycles 2..5 with matching rdata, then gnt=0.
- Contention: req=3'b111, all len=2, pointer=0 -> grant order 0, 1, 2, back-to-back with no idle cycle; then pointer=0.
- Abort: req[1] drops after beat 2 of a 28-beat burst -> no beat that cycle, gnt drops next cycle, next grant goes to requester 2.
- Zero length: len=0 -> exactly one beat issued.
- Reset mid-burst: rst high during beat 5 of 10 -> next cycle gnt=0, rvalid=0, ram_en=0, owner=0; no beat count carried over afterwards.
- Stats (MEM_ARB_STATS_EN): three bursts of 28 beats on requester 2 -> stat_beats[2]=84; stat_clr in the same cycle as a beat -> 0.
